alu_muldiv_seq: RTL



---
 rtl/alu_muldiv_seq_if.sv | 28 ++
 rtl/alu_muldiv_seq.sv | 129 ++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq_if.sv
// Bus between the core and the iterative mul/div sequencer, including the
// borrowed-ALU request path.
interface alu_muldiv_seq_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        alu_req;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctr;
  logic [31:0] alu_result;

  // Core side: issues requests and owns the shared ALU.
  modport master (
    output start, op, rs1, rs2, alu_result,
    input  busy, done, result, alu_req, alu_a, alu_b, alu_ctr
  );

  // Sequencer side.
  modport slave (
    input  start, op, rs1, rs2, alu_result,
    output busy, done, result, alu_req, alu_a, alu_b, alu_ctr
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer. It borrows the core ALU for one
// add (shift-add multiply) or one sub (restoring divide) per cycle over
// 32 iterations, then applies sign correction.
module alu_muldiv_seq (
  input logic             clock,
  input logic             reset,
  alu_muldiv_seq_if.slave bus
);

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIN, DONE} state_t;

  state_t      state, state_nx;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;
  // hi/lo: product {hi,lo} for multiply, {rem,quo} for divide.
  // m: multiplicand for multiply, divisor for divide.
  logic [31:0] hi, lo, m;
  logic [4:0]  cnt;
  logic [31:0] res_q;

  logic        is_mul, sgn_a, sgn_b, div0, ovf, special;
  logic [31:0] mag_a, mag_b, spec_res;
  logic        carry, ge;
  logic [31:0] sh;
  logic        neg_p, neg_q, neg_r;
  logic [63:0] prod, prod_c;
  logic [31:0] mul_res, div_res;

  assign is_mul = ~op_q[2];
  assign sgn_a  = is_mul ? (op_q == 3'b001 || op_q == 3'b010) : ~op_q[0];
  assign sgn_b  = is_mul ? (op_q == 3'b001) : ~op_q[0];
  assign mag_a  = (sgn_a && a_q[31]) ? -a_q : a_q;
  assign mag_b  = (sgn_b && b_q[31]) ? -b_q : b_q;

  assign div0     = ~is_mul && (b_q == '0);
  assign ovf      = ~is_mul && ~op_q[0] && (a_q == 32'h8000_0000) && (b_q == '1);
  assign special  = div0 | ovf;
  assign spec_res = op_q[1] ? (div0 ? a_q : '0) : (div0 ? '1 : 32'h8000_0000);

  assign carry = bus.alu_result < hi;
  assign sh    = {hi[30:0], lo[31]};
  assign ge    = hi[31] | (sh >= m);

  assign neg_p   = ((op_q == 3'b001) && (a_q[31] ^ b_q[31])) ||
                   ((op_q == 3'b010) && a_q[31]);
  assign prod    = {hi, lo};
  assign prod_c  = neg_p ? -prod : prod;
  assign mul_res = (op_q == 3'b000) ? prod_c[31:0] : prod_c[63:32];
  assign neg_q   = ~op_q[0] && (a_q[31] ^ b_q[31]);
  assign neg_r   = ~op_q[0] && a_q[31];
  assign div_res = op_q[1] ? (neg_r ? -hi : hi) : (neg_q ? -lo : lo);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.start) state_nx = PREP;
      PREP: state_nx = special ? DONE : ITER;
      ITER: if (cnt == 5'd31) state_nx = FIN;
      FIN:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs, including the ALU request that is forced to zero outside ITER.
  always_comb begin
    bus.busy    = (state != IDLE);
    bus.done    = (state == DONE);
    bus.result  = res_q;
    bus.alu_req = (state == ITER);
    bus.alu_a   = '0;
    bus.alu_b   = '0;
    bus.alu_ctr = '0;
    if (state == ITER) begin
      bus.alu_a   = is_mul ? hi : sh;
      bus.alu_b   = is_mul ? (lo[0] ? m : '0) : m;
      bus.alu_ctr = is_mul ? 4'b0000 : 4'b1000;
    end
  end

  // Operand latch, iteration datapath and result register.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
      m     <= '0;
      cnt   <= '0;
      res_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          op_q <= bus.op;
          a_q  <= bus.rs1;
          b_q  <= bus.rs2;
        end
        PREP: begin
          hi  <= '0;
          lo  <= is_mul ? mag_b : mag_a;
          m   <= is_mul ? mag_a : mag_b;
          cnt <= '0;
          if (special) res_q <= spec_res;
        end
        ITER: begin
          cnt <= cnt + 5'd1;
          if (is_mul) begin
            hi <= {carry, bus.alu_result[31:1]};
            lo <= {bus.alu_result[0], lo[31:1]};
          end else begin
            hi <= ge ? bus.alu_result : sh;
            lo <= {lo[30:0], ge};
          end
        end
        FIN: res_q <= is_mul ? mul_res : div_res;
        default: ;
      endcase
    end
  end

endmodule
